// File: rtl/vga_pkg.sv
// vga_pkg: phase encoding, reset timing and bar colours shared by the
// VGA timing sequencer and its per-axis phase counters.
package vga_pkg;

  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } phase_e;

  localparam int DEF_H_ACT = 640;
  localparam int DEF_H_FP  = 16;
  localparam int DEF_H_SYN = 96;
  localparam int DEF_H_BP  = 48;
  localparam int DEF_V_ACT = 480;
  localparam int DEF_V_FP  = 10;
  localparam int DEF_V_SYN = 2;
  localparam int DEF_V_BP  = 33;

  function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
    logic [11:0] c;
    c = 12'h000;
    unique case (idx)
      3'd0: c = 12'hFFF;
      3'd1: c = 12'hFF0;
      3'd2: c = 12'h0FF;
      3'd3: c = 12'h0F0;
      3'd4: c = 12'hF0F;
      3'd5: c = 12'hF00;
      3'd6: c = 12'h00F;
      3'd7: c = 12'h000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_axis_seq.sv
// vga_axis_seq: one timing axis, ACTIVE -> FRONT -> SYNC -> BACK,
// with a phase counter that steps only when adv is high.
module vga_axis_seq
  import vga_pkg::*;
#(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv,
  input  logic [W-1:0] act,
  input  logic [W-1:0] fp,
  input  logic [W-1:0] sync,
  input  logic [W-1:0] bp,
  output phase_e       phase,
  output logic [W-1:0] pos,
  output logic         last
);

  phase_e       ph_q, ph_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] len;
  logic         ph_end;

  always_comb begin
    len = act;
    unique case (ph_q)
      ACTIVE: len = act;
      FRONT:  len = fp;
      SYNC:   len = sync;
      BACK:   len = bp;
    endcase
    // lengths are never zero, so len-1 cannot underflow
    ph_end = (cnt_q == len - W'(1));
    ph_d   = ph_q;
    cnt_d  = cnt_q;
    if (adv) begin
      if (ph_end) begin
        cnt_d = '0;
        ph_d  = phase_e'(ph_q + 2'd1);
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q  <= ACTIVE;
      cnt_q <= '0;
    end else begin
      ph_q  <= ph_d;
      cnt_q <= cnt_d;
    end
  end

  assign phase = ph_q;
  assign pos   = cnt_q;
  assign last  = (ph_q == BACK) && ph_end;

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: programmable VGA sync/DE sequencer, shadowed config
// applied at frame end. VGA_TEST_PATTERN_EN adds an 8-bar rgb output.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_W      = 11,
  parameter int V_W      = 10,
  parameter bit SYNC_POL = 1'b0,
  parameter int H_ACT_D  = DEF_H_ACT,
  parameter int H_FP_D   = DEF_H_FP,
  parameter int H_SYN_D  = DEF_H_SYN,
  parameter int H_BP_D   = DEF_H_BP,
  parameter int V_ACT_D  = DEF_V_ACT,
  parameter int V_FP_D   = DEF_V_FP,
  parameter int V_SYN_D  = DEF_V_SYN,
  parameter int V_BP_D   = DEF_V_BP
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic           cfg_sel,
  input  logic [H_W-1:0] cfg_act,
  input  logic [H_W-1:0] cfg_fp,
  input  logic [H_W-1:0] cfg_sync,
  input  logic [H_W-1:0] cfg_bp,
  output logic           cfg_err,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [H_W-1:0] px_x,
  output logic [V_W-1:0] px_y,
  output logic           line_start,
  output logic           frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [11:0]    rgb
`endif
);

  typedef struct packed {
    logic [H_W-1:0] act;
    logic [H_W-1:0] fp;
    logic [H_W-1:0] sync;
    logic [H_W-1:0] bp;
  } hset_t;

  typedef struct packed {
    logic [V_W-1:0] act;
    logic [V_W-1:0] fp;
    logic [V_W-1:0] sync;
    logic [V_W-1:0] bp;
  } vset_t;

  localparam hset_t H_RST = '{act: H_W'(H_ACT_D), fp: H_W'(H_FP_D),
                              sync: H_W'(H_SYN_D), bp: H_W'(H_BP_D)};
  localparam vset_t V_RST = '{act: V_W'(V_ACT_D), fp: V_W'(V_FP_D),
                              sync: V_W'(V_SYN_D), bp: V_W'(V_BP_D)};

  hset_t          h_live_q, h_live_d, h_shd_q, h_shd_d;
  vset_t          v_live_q, v_live_d, v_shd_q, v_shd_d;
  logic           h_pend_q, h_pend_d, v_pend_q, v_pend_d;
  logic           err_q, err_d;
  logic           de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic           ls_q, ls_d, fs_q, fs_d;
  logic [H_W-1:0] px_x_q, px_x_d;
  logic [V_W-1:0] px_y_q, px_y_d;

  phase_e         h_ph, v_ph;
  logic [H_W-1:0] h_pos;
  logic [V_W-1:0] v_pos;
  logic           h_last, v_last, frame_end;
  logic           acc, bad, hi;

  vga_axis_seq #(.W(H_W)) u_h (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (1'b1),
    .act   (h_live_q.act),
    .fp    (h_live_q.fp),
    .sync  (h_live_q.sync),
    .bp    (h_live_q.bp),
    .phase (h_ph),
    .pos   (h_pos),
    .last  (h_last)
  );

  vga_axis_seq #(.W(V_W)) u_v (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (h_last),
    .act   (v_live_q.act),
    .fp    (v_live_q.fp),
    .sync  (v_live_q.sync),
    .bp    (v_live_q.bp),
    .phase (v_ph),
    .pos   (v_pos),
    .last  (v_last)
  );

  assign frame_end = h_last && v_last;
  assign cfg_ready = !(h_pend_q || v_pend_q);

  always_comb begin
    acc = cfg_valid && cfg_ready;
    hi  = cfg_sel && (|{cfg_act[H_W-1:V_W], cfg_fp[H_W-1:V_W],
                        cfg_sync[H_W-1:V_W], cfg_bp[H_W-1:V_W]});
    bad = (cfg_act == '0) || (cfg_fp == '0) ||
          (cfg_sync == '0) || (cfg_bp == '0) || hi;
    h_shd_d  = h_shd_q;
    v_shd_d  = v_shd_q;
    h_live_d = (frame_end && h_pend_q) ? h_shd_q : h_live_q;
    v_live_d = (frame_end && v_pend_q) ? v_shd_q : v_live_q;
    h_pend_d = frame_end ? 1'b0 : h_pend_q;
    v_pend_d = frame_end ? 1'b0 : v_pend_q;
    err_d    = 1'b0;
    // a request on the frame-end cycle is only seen when nothing is pending
    if (acc) begin
      if (bad) begin
        err_d = 1'b1;
      end else if (cfg_sel) begin
        v_shd_d  = '{act: cfg_act[V_W-1:0], fp: cfg_fp[V_W-1:0],
                     sync: cfg_sync[V_W-1:0], bp: cfg_bp[V_W-1:0]};
        v_pend_d = 1'b1;
      end else begin
        h_shd_d  = '{act: cfg_act, fp: cfg_fp, sync: cfg_sync, bp: cfg_bp};
        h_pend_d = 1'b1;
      end
    end
  end

  always_comb begin
    de_d   = (h_ph == ACTIVE) && (v_ph == ACTIVE);
    hs_d   = (h_ph == SYNC) ? SYNC_POL : !SYNC_POL;
    vs_d   = (v_ph == SYNC) ? SYNC_POL : !SYNC_POL;
    px_x_d = de_d ? h_pos : '0;
    px_y_d = (v_ph == ACTIVE) ? v_pos : '0;
    ls_d   = (h_ph == ACTIVE) && (h_pos == '0);
    fs_d   = ls_d && (v_ph == ACTIVE) && (v_pos == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_live_q <= H_RST;
      h_shd_q  <= H_RST;
      v_live_q <= V_RST;
      v_shd_q  <= V_RST;
      h_pend_q <= 1'b0;
      v_pend_q <= 1'b0;
      err_q    <= 1'b0;
      de_q     <= 1'b0;
      hs_q     <= !SYNC_POL;
      vs_q     <= !SYNC_POL;
      px_x_q   <= '0;
      px_y_q   <= '0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      h_live_q <= h_live_d;
      h_shd_q  <= h_shd_d;
      v_live_q <= v_live_d;
      v_shd_q  <= v_shd_d;
      h_pend_q <= h_pend_d;
      v_pend_q <= v_pend_d;
      err_q    <= err_d;
      de_q     <= de_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      px_x_q   <= px_x_d;
      px_y_q   <= px_y_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
    end
  end

  assign cfg_err     = err_q;
  assign de          = de_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign px_x        = px_x_q;
  assign px_y        = px_y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

`ifdef VGA_TEST_PATTERN_EN
  // edge k = ceil(k*act/8): px_x >= edge k  <=>  8*px_x >= k*act
  function automatic logic [H_W-1:0] bar_edge(input logic [H_W-1:0] a,
                                               input int k);
    logic [H_W+2:0] p;
    p = (H_W+3)'(a) * (H_W+3)'(k) + (H_W+3)'(7);
    return p[H_W+2:3];
  endfunction

  logic [H_W-1:0] bnd_q [7];
  logic [H_W-1:0] bnd_d [7];
  logic [2:0]     bar;
  logic [11:0]    rgb_q, rgb_d;

  always_comb begin
    bar = '0;
    for (int k = 0; k < 7; k++) begin
      bnd_d[k] = frame_end ? bar_edge(h_live_d.act, k + 1) : bnd_q[k];
      if (h_pos >= bnd_q[k]) bar = bar + 3'd1;
    end
    rgb_d = de_d ? bar_rgb(bar) : 12'h000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 7; k++) bnd_q[k] <= bar_edge(H_W'(H_ACT_D), k + 1);
      rgb_q <= 12'h000;
    end else begin
      for (int k = 0; k < 7; k++) bnd_q[k] <= bnd_d[k];
      rgb_q <= rgb_d;
    end
  end

  assign rgb = rgb_q;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: directed checks of sync/de/strobes, shadowed
// reconfiguration, rejects, back-to-back requests, reset and test bars.
module tb_vga_timing_ctrl;

  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_sel = 1'b0;
  logic [10:0] cfg_act = '0;
  logic [10:0] cfg_fp = '0;
  logic [10:0] cfg_sync = '0;
  logic [10:0] cfg_bp = '0;
  logic        cfg_ready, cfg_err, hsync, vsync, de;
  logic        line_start, frame_start;
  logic [10:0] px_x;
  logic [9:0]  px_y;
`ifdef VGA_TEST_PATTERN_EN
  logic [11:0] rgb;
  logic [11:0] colours [8];
`endif

  int total = 0;
  int bad = 0;
  int mm = 0;
  int first_bad = -1;

  always #5 clk = ~clk;

  vga_timing_ctrl #(
    .V_ACT_D (VA),
    .V_FP_D  (VF),
    .V_SYN_D (VS),
    .V_BP_D  (VB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_sel     (cfg_sel),
    .cfg_act     (cfg_act),
    .cfg_fp      (cfg_fp),
    .cfg_sync    (cfg_sync),
    .cfg_bp      (cfg_bp),
    .cfg_err     (cfg_err),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .px_x        (px_x),
    .px_y        (px_y),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef VGA_TEST_PATTERN_EN
    ,
    .rgb         (rgb)
`endif
  );

  task automatic drive(input logic v, input logic sel,
                       input int a, input int f, input int s, input int b);
    cfg_valid = v;
    cfg_sel   = sel;
    cfg_act   = 11'(a);
    cfg_fp    = 11'(f);
    cfg_sync  = 11'(s);
    cfg_bp    = 11'(b);
  endtask

  // reference timing model; sample index i counts from the frame_start cycle
  task automatic scan(input int start, input int n,
                      input int ha, input int hf, input int hs, input int hb);
    int ht, x, l, ex, ey;
    logic ed, eh, ev, el, ef;
    ht = ha + hf + hs + hb;
    for (int i = start; i < start + n; i++) begin
      x  = i % ht;
      l  = (i / ht) % VT;
      ed = (x < ha) && (l < VA);
      eh = !((x >= ha + hf) && (x < ha + hf + hs));
      ev = !((l >= VA + VF) && (l < VA + VF + VS));
      el = (x == 0);
      ef = (x == 0) && (l == 0);
      ex = ed ? x : 0;
      ey = (l < VA) ? l : 0;
      if (de !== ed || px_x !== 11'(ex) || px_y !== 10'(ey) ||
          hsync !== eh || vsync !== ev ||
          line_start !== el || frame_start !== ef) begin
        mm++;
        if (first_bad < 0) first_bad = i;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    total++;
    if ({de, hsync, vsync, line_start, frame_start, cfg_ready, cfg_err}
          !== 7'b0110010 || px_x !== 11'd0 || px_y !== 10'd0) begin
      bad++;
      $display("FAIL reset_vals: de=%b hs=%b vs=%b ls=%b fs=%b rdy=%b err=%b x=%0d y=%0d want 0 1 1 0 0 1 0 0 0",
               de, hsync, vsync, line_start, frame_start, cfg_ready,
               cfg_err, px_x, px_y);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({de, frame_start, line_start} !== 3'b111 || px_x !== 11'd0 ||
        px_y !== 10'd0) begin
      bad++;
      $display("FAIL first_pixel: de=%b fs=%b ls=%b x=%0d y=%0d want 1 1 1 0 0",
               de, frame_start, line_start, px_x, px_y);
    end
  endtask

  task automatic test_default();
    mm = 0;
    first_bad = -1;
    scan(0, 2 * 800 * VT, 640, 16, 96, 48);
    total++;
    if (mm !== 0) begin
      bad++;
      $display("FAIL default_frames: mismatches=%0d first_at=%0d want 0",
               mm, first_bad);
    end
  endtask

  task automatic test_h_update();
    mm = 0;
    first_bad = -1;
    scan(0, 1000, 640, 16, 96, 48);
    drive(1'b1, 1'b0, 320, 8, 48, 24);
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL upd_ready_idle: got %b want 1", cfg_ready);
    end
    scan(1000, 1, 640, 16, 96, 48);
    cfg_valid = 1'b0;
    total++;
    if (cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL upd_accept: rdy=%b err=%b want 0 0", cfg_ready, cfg_err);
    end
    scan(1001, 800 * VT - 1003, 640, 16, 96, 48);
    total++;
    if (cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL upd_pending_held: got %b want 0", cfg_ready);
    end
    scan(800 * VT - 2, 1, 640, 16, 96, 48);
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL upd_ready_back: got %b want 1", cfg_ready);
    end
    scan(800 * VT - 1, 1, 640, 16, 96, 48);
    scan(0, 400 * VT, 320, 8, 48, 24);
    total++;
    if (mm !== 0) begin
      bad++;
      $display("FAIL upd_timing: mismatches=%0d first_at=%0d want 0",
               mm, first_bad);
    end
  endtask

  task automatic test_bad_cfg();
    mm = 0;
    first_bad = -1;
    drive(1'b1, 1'b0, 100, 0, 10, 10);
    scan(0, 1, 320, 8, 48, 24);
    cfg_valid = 1'b0;
    total++;
    if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL bad_fp_err: err=%b rdy=%b want 1 1", cfg_err, cfg_ready);
    end
    scan(1, 1, 320, 8, 48, 24);
    total++;
    if (cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL bad_fp_pulse: err=%b want 0", cfg_err);
    end
    drive(1'b1, 1'b1, 11'h400, 1, 1, 1);
    scan(2, 1, 320, 8, 48, 24);
    cfg_valid = 1'b0;
    total++;
    if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL bad_v_high: err=%b rdy=%b want 1 1", cfg_err, cfg_ready);
    end
    scan(3, 400 * VT - 3, 320, 8, 48, 24);
    scan(0, 400 * VT, 320, 8, 48, 24);
    total++;
    if (mm !== 0) begin
      bad++;
      $display("FAIL bad_unchanged: mismatches=%0d first_at=%0d want 0",
               mm, first_bad);
    end
  endtask

  task automatic test_back_to_back();
    int acc, last_acc;
    acc = 0;
    last_acc = -1;
    mm = 0;
    first_bad = -1;
    drive(1'b1, 1'b0, 640, 16, 96, 48);
    for (int i = 0; i < 400 * VT; i++) begin
      if (cfg_ready === 1'b1) begin
        acc++;
        last_acc = i;
      end
      scan(i, 1, 320, 8, 48, 24);
      if (i == 0) drive(1'b1, 1'b0, 200, 10, 20, 10);
    end
    cfg_valid = 1'b0;
    total++;
    if (acc !== 2 || last_acc !== 400 * VT - 1) begin
      bad++;
      $display("FAIL b2b_accepts: count=%0d last=%0d want 2 %0d",
               acc, last_acc, 400 * VT - 1);
    end
    total++;
    if (cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second_pending: got %b want 0", cfg_ready);
    end
    scan(0, 800 * VT, 640, 16, 96, 48);
    scan(0, 240 * VT, 200, 10, 20, 10);
    total++;
    if (mm !== 0) begin
      bad++;
      $display("FAIL b2b_timing: mismatches=%0d first_at=%0d want 0",
               mm, first_bad);
    end
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready_end: got %b want 1", cfg_ready);
    end
  endtask

  task automatic test_reset_mid();
    mm = 0;
    first_bad = -1;
    drive(1'b1, 1'b0, 320, 8, 48, 24);
    scan(0, 1, 200, 10, 20, 10);
    cfg_valid = 1'b0;
    total++;
    if (cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_pend_set: got %b want 0", cfg_ready);
    end
    scan(1, 819, 200, 10, 20, 10);
    total++;
    if (px_x !== 11'd100 || px_y !== 10'd3 || de !== 1'b1) begin
      bad++;
      $display("FAIL rst_position: x=%0d y=%0d de=%b want 100 3 1",
               px_x, px_y, de);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({de, hsync, vsync, line_start, frame_start, cfg_ready, cfg_err}
          !== 7'b0110010 || px_x !== 11'd0 || px_y !== 10'd0) begin
      bad++;
      $display("FAIL rst_async: de=%b hs=%b vs=%b ls=%b fs=%b rdy=%b err=%b x=%0d y=%0d want 0 1 1 0 0 1 0 0 0",
               de, hsync, vsync, line_start, frame_start, cfg_ready,
               cfg_err, px_x, px_y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({frame_start, line_start, de, cfg_ready} !== 4'b1111) begin
      bad++;
      $display("FAIL rst_restart: fs=%b ls=%b de=%b rdy=%b want 1 1 1 1",
               frame_start, line_start, de, cfg_ready);
    end
    scan(0, 800 * VT, 640, 16, 96, 48);
    scan(0, 800, 640, 16, 96, 48);
    total++;
    if (mm !== 0) begin
      bad++;
      $display("FAIL rst_discard: mismatches=%0d first_at=%0d want 0",
               mm, first_bad);
    end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    int cnt, fx;
    logic [11:0] exp;
    cnt = 0;
    fx = -1;
    colours = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                12'hF0F, 12'hF00, 12'h00F, 12'h000};
    for (int i = 0; i < 800; i++) begin
      exp = (i < 640) ? colours[i / 80] : 12'h000;
      if (i == 80) begin
        total++;
        if (rgb !== 12'hFF0) begin
          bad++;
          $display("FAIL bar_edge80: got %h want ff0", rgb);
        end
      end
      if (rgb !== exp) begin
        cnt++;
        if (fx < 0) fx = i;
      end
      @(negedge clk);
    end
    total++;
    if (cnt !== 0) begin
      bad++;
      $display("FAIL bar_line: mismatches=%0d first_x=%0d want 0", cnt, fx);
    end
  endtask
`endif

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_default();
    test_h_update();
    test_bad_cfg();
    test_back_to_back();
    test_reset_mid();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Programmable VGA timing sequencer. It drives horizontal and vertical sync, data-enable and pixel coordinates, and sequences the display datapath by emitting line-start and frame-start strobes. Software reprograms the porch, sync and active lengths through a valid/ready config port. New values take effect only at a frame boundary, so a frame is never torn. It replaces free-running threshold counters in the video output path and feeds the pixel fetch logic.

Parameters:
H_W, 11, width of horizontal length fields and the px_x counter
V_W, 10, width of vertical length fields and the px_y counter
SYNC_POL, 0, asserted level of hsync and vsync (0 = active-low)
H_ACT_D/H_FP_D/H_SYN_D/H_BP_D, 640/16/96/48, reset horizontal lengths (line total 800)
V_ACT_D/V_FP_D/V_SYN_D/V_BP_D, 480/10/2/33, reset vertical lengths (frame total 525)

Ports:
clk  in  1  pixel clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  config request
cfg_ready  out  1  config accepted when cfg_valid && cfg_ready
cfg_sel  in  1  0 = horizontal set, 1 = vertical set
cfg_act/cfg_fp/cfg_sync/cfg_bp  in  H_W each  phase lengths (vertical set uses the low V_W bits)
cfg_err  out  1  one-cycle pulse when a request is rejected
hsync, vsync  out  1  sync outputs at SYNC_POL level while in the SYNC phase
de  out  1  high when both axes are in ACTIVE
px_x  out  H_W  column index (0..act-1) while de, else 0
px_y  out  V_W  line index while the vertical axis is ACTIVE, else 0
line_start  out  1  pulse on the first cycle of every line
frame_start  out  1  pulse on the first cycle of every frame (px_x = 0, px_y = 0)

Behaviour:
- Clocking and reset: one clock, reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - Both axes in ACTIVE, counters 0, live and shadow registers loaded with the *_D defaults, no update pending.
  - Outputs: de = 0, hsync = vsync = !SYNC_POL, px_x = px_y = 0, line_start = frame_start = 0, cfg_ready = 1, cfg_err = 0.
- Each axis is a 4-state FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
  - The phase counter runs 0..len-1 and clears on each phase change.
- Horizontal axis advances every cycle.
- Vertical axis advances only on a line-end tick (last cycle of horizontal BACK).
- Outputs are registered from the current state: one cycle latency.
  - First cycle after rst_n rises: counters at 0. Next cycle: de = 1, px = (0,0), frame_start = 1, line_start = 1.
- Frame end = line-end tick while the vertical axis is in the last cycle of BACK.
- Config handshake:
  - On an accepted request, the fields are checked first.
  - Any field = 0, or (vertical) any field with nonzero bits above V_W: cfg_err pulses the next cycle and nothing is stored.
  - Otherwise the fields are written to the selected shadow set, that set's pending flag is set, and cfg_ready drops the next cycle.
  - cfg_ready = !(h_pending || v_pending).
- At frame end, all pending shadow sets copy into the live registers and the pending flags clear.
  - The next frame uses the new values and cfg_ready returns high on that first cycle.
- A request arriving on the frame-end cycle is not accepted (cfg_ready is already low while pending).
  - If nothing was pending, it is accepted and applies at the following frame end.
- Counter widths: wrap is impossible because lengths are bounded by the field widths; the counter is compared with len-1 computed at field width.
- Reset mid-frame: timing restarts immediately at (0,0) and any pending update is discarded.

Optional Feature:
VGA_TEST_PATTERN_EN:
- Defined: adds output rgb[11:0].
  - Eight vertical colour bars; bar index = (px_x * 8) / h_act, computed with a registered divide-free compare against precomputed bar edges.
  - Bar edges are recomputed at frame end.
  - Colours in order: white, yellow, cyan, green, magenta, red, blue, black. rgb = 0 when !de.
  - rgb is aligned with de, with no extra latency.
- Undefined: the port and its logic are absent.

Decomposition:
- Package vga_pkg: phase enum {ACTIVE, FRONT, SYNC, BACK}, default timing constants, test-pattern colour table.
- Sub-module vga_axis_seq, instantiated twice (H and V):
  - Inputs: advance enable, live lengths.
  - Outputs: phase, position, last-cycle flag.

Test Plan:
1. Reset, default config, run 2 frames -> de high for 640 cycles per line; hsync low for 96 cycles starting 656 cycles after line start; line period 800; frame period 420000 cycles; frame_start once per frame.
2. Program H {320,8,48,24} mid-frame -> cfg_ready low until frame end; the current frame keeps an 800-cycle line period; the next frame has a 400-cycle line and de 320 cycles; cfg_ready back high.
3. Config with cfg_fp = 0 -> cfg_err one-cycle pulse; cfg_ready stays 1; timing unchanged.
4. Assert cfg_valid every cycle across a frame end with an H update pending -> exactly one acceptance after the apply; no lost or duplicate update.
5. Assert rst_n low at px (100,200) -> all outputs at reset values asynchronously; after release frame_start follows in 2 cycles; the pending update is gone.
6. VGA_TEST_PATTERN_EN, default mode -> rgb = 0xFFF for px_x 0..79, 0xFF0 for 80..159, …, 0x000 for 560..639; rgb = 0 in porches.
